ram_stream_reader: RTL

//  Read-side engine for a 1R1W RAM with combinational (same-cycle) read data.

---
 rtl/ram_stream_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams a {start, length} window of a 1R1W RAM as valid/ready beats.
// Optional last_o output enabled by defining RAM_STREAM_READER_LAST_EN.
module ram_stream_reader #(
    parameter int width_p = 8,
    parameter int depth_p = 8,
    localparam int aw = $clog2(depth_p),
    localparam int lw = $clog2(depth_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [aw-1:0]      cmd_addr_i,
    input  logic [lw-1:0]      cmd_len_i,
    output logic [aw-1:0]      rd_addr_o,
    input  logic [width_p-1:0] rd_data_i,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i,
`ifdef RAM_STREAM_READER_LAST_EN
    output logic               last_o,
`endif
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [aw-1:0]   addr_q;
    logic [aw-1:0]   addr_nxt;
    logic [lw-1:0]   rem_q;
    logic [lw-1:0]   rem_base;
    logic            cmd_fire;
    logic            out_fire;
    logic            load;
    logic            load_last;
    logic            zero_done_q;
`ifdef RAM_STREAM_READER_LAST_EN
    logic            last_q;
`endif

    assign cmd_fire = cmd_valid_i && (state_q == IDLE);
    assign out_fire = valid_o && ready_i;

    // The first word is fetched in the command cycle itself so it is visible one cycle later.
    always_comb begin
        load      = 1'b0;
        load_last = 1'b0;
        rem_base  = rem_q;
        unique case (state_q)
            IDLE: begin
                load      = cmd_fire && (cmd_len_i != '0);
                load_last = (cmd_len_i == lw'(1));
                rem_base  = cmd_len_i;
            end
            READ: begin
                load      = !valid_o || ready_i;
                load_last = (rem_q == lw'(1));
            end
            default: begin
                load      = 1'b0;
            end
        endcase
        addr_nxt = (rd_addr_o == aw'(depth_p - 1)) ? '0 : rd_addr_o + aw'(1);
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = load_last ? DRAIN : READ;
                end
            end
            READ: begin
                if (load && load_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs derived from the state; the read address follows the command while idle.
    always_comb begin
        cmd_ready_o = (state_q == IDLE);
        busy_o      = (state_q != IDLE) || valid_o;
        done_o      = ((state_q == DRAIN) && out_fire) || zero_done_q;
        rd_addr_o   = addr_q;
        if ((state_q == IDLE) && cmd_valid_i) begin
            rd_addr_o = cmd_addr_i;
        end
    end

    // Address walker, remaining count and output register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q      <= '0;
            rem_q       <= '0;
            valid_o     <= 1'b0;
            data_o      <= '0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= cmd_fire && (cmd_len_i == '0);
            if (load) begin
                addr_q  <= addr_nxt;
                rem_q   <= rem_base - lw'(1);
                data_o  <= rd_data_i;
                valid_o <= 1'b1;
            end else if (out_fire) begin
                valid_o <= 1'b0;
            end
        end
    end

`ifdef RAM_STREAM_READER_LAST_EN
    // Marks the final word of the command while it sits in the output register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_q <= 1'b0;
        end else if (load) begin
            last_q <= load_last;
        end else if (out_fire) begin
            last_q <= 1'b0;
        end
    end

    assign last_o = last_q;
`endif

endmodule
